// File: rtl/instr_prefetch_queue_if.sv
// Handshake bundle between an instruction source/consumer and instr_prefetch_queue.
// master drives the producer/consumer side; slave is the queue itself.
interface instr_prefetch_queue_if #(
  parameter int INS_W   = 16,
  parameter int FIELD_W = 4,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               flush;
  logic               in_valid;
  logic [INS_W-1:0]   ins;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [FIELD_W-1:0] opcode;
  logic [FIELD_W-1:0] DR;
  logic [FIELD_W-1:0] SA;
  logic [FIELD_W-1:0] SB;
  logic [CNT_W-1:0]   count;

  modport master (
    output flush, in_valid, ins, out_ready,
    input  in_ready, out_valid, opcode, DR, SA, SB, count
  );

  modport slave (
    input  flush, in_valid, ins, out_ready,
    output in_ready, out_valid, opcode, DR, SA, SB, count
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Circular instruction FIFO feeding a registered decode stage (opcode/DR/SA/SB).
// No bypass: a word always spends at least one cycle in the FIFO before issue.
module instr_prefetch_queue #(
  parameter int INS_W   = 16,
  parameter int FIELD_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic                  clk_main,
  input  logic                  reset,
  instr_prefetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic [INS_W-1:0] head;
  logic             enq;
  logic             load;

  always_comb begin
    bus.in_ready = (cnt < CNT_W'(DEPTH));
    bus.count    = cnt;
    head         = mem[rptr];
    enq          = bus.in_valid && bus.in_ready && !bus.flush;
    load         = (cnt != '0) && (!bus.out_valid || bus.out_ready) && !bus.flush;
  end

  // Storage is deliberately unreset; pointers/count guarantee stale entries never issue.
  always_ff @(posedge clk_main) begin
    if (enq)
      mem[wptr] <= bus.ins;
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      wptr          <= '0;
      rptr          <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.opcode    <= '0;
      bus.DR        <= '0;
      bus.SA        <= '0;
      bus.SB        <= '0;
    end else if (bus.flush) begin
      wptr          <= '0;
      rptr          <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (enq)
        wptr <= wptr + PTR_W'(1);
      if (load) begin
        rptr          <= rptr + PTR_W'(1);
        bus.out_valid <= 1'b1;
        bus.opcode    <= head[INS_W-1 -: FIELD_W];
        bus.DR        <= head[3*FIELD_W-1 -: FIELD_W];
        bus.SA        <= head[2*FIELD_W-1 -: FIELD_W];
        bus.SB        <= head[FIELD_W-1:0];
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      case ({enq, load})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a wide-parameter instance.
module tb_instr_prefetch_queue;
  logic clk_main = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_main = ~clk_main;

  instr_prefetch_queue_if #(.INS_W(16), .FIELD_W(4), .DEPTH(4)) bus ();
  instr_prefetch_queue_if #(.INS_W(32), .FIELD_W(8), .DEPTH(8)) bus2 ();

  instr_prefetch_queue #(.INS_W(16), .FIELD_W(4), .DEPTH(4)) dut (
    .clk_main(clk_main), .reset(reset), .bus(bus)
  );
  instr_prefetch_queue #(.INS_W(32), .FIELD_W(8), .DEPTH(8)) dut2 (
    .clk_main(clk_main), .reset(reset), .bus(bus2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue plus one output slot.
  logic [15:0] q[$];
  logic        m_valid = 1'b0;
  logic [15:0] m_word  = '0;
  bit          chk_en  = 1'b0;

  always @(posedge clk_main) begin
    if (reset) begin
      q.delete();
      m_valid = 1'b0;
      m_word  = '0;
      chk_en  = 1'b1;
    end else if (bus.flush) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      bit acc;
      acc = bus.in_valid && (q.size() < 4);
      if (q.size() > 0 && (!m_valid || bus.out_ready)) begin
        m_word  = q.pop_front();
        m_valid = 1'b1;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
      if (acc) q.push_back(bus.ins);
    end
  end

  always @(negedge clk_main) begin
    if (chk_en) begin
      chk("count",     64'(bus.count),     64'(q.size()));
      chk("in_ready",  64'(bus.in_ready),  64'(q.size() < 4));
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("fields",    64'({bus.opcode, bus.DR, bus.SA, bus.SB}), 64'(m_word));
    end
  end

  task automatic tick(input logic rst, input logic fl, input logic iv,
                      input logic [15:0] w, input logic ordy);
    reset         = rst;
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.ins       = w;
    bus.out_ready = ordy;
    @(negedge clk_main);
  endtask

  task automatic tick2(input logic iv, input logic [31:0] w, input logic ordy);
    bus2.in_valid  = iv;
    bus2.ins       = w;
    bus2.out_ready = ordy;
    @(negedge clk_main);
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.ins = '0; bus.out_ready = 1'b0;
    bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.ins = '0; bus2.out_ready = 1'b0;
    @(negedge clk_main);
    tick(1, 0, 0, 16'h0, 0);
    tick(1, 0, 0, 16'h0, 0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count",     64'(bus.count),     64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_opcode",    64'(bus.opcode),    64'd0);

    // Single word: accepted at first edge, issued at the next.
    tick(0, 0, 1, 16'h1234, 1);
    chk("single_lat_valid", 64'(bus.out_valid), 64'd0);
    tick(0, 0, 0, 16'h0, 0);
    chk("single_valid",  64'(bus.out_valid), 64'd1);
    chk("single_opcode", 64'(bus.opcode), 64'd1);
    chk("single_DR",     64'(bus.DR),     64'd2);
    chk("single_SA",     64'(bus.SA),     64'd3);
    chk("single_SB",     64'(bus.SB),     64'd4);
    chk("single_count",  64'(bus.count),  64'd0);
    tick(0, 0, 0, 16'h0, 1);
    chk("consume_valid",  64'(bus.out_valid), 64'd0);
    chk("consume_opcode", 64'(bus.opcode),    64'd1);

    // Fill with stalled output.
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 16'hA000 + 16'(i), 0);
    tick(0, 0, 1, 16'hA005, 0);
    tick(0, 0, 1, 16'hA005, 0);
    chk("full_count",    64'(bus.count),    64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_word", 64'({bus.opcode, bus.DR, bus.SA, bus.SB}), 64'h A000);
    tick(0, 0, 1, 16'hA005, 1);
    chk("full_load_count", 64'(bus.count), 64'd3);
    tick(0, 0, 1, 16'hA005, 1);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 16'h0, 1);
    chk("drained_valid", 64'(bus.out_valid), 64'd0);

    // Streaming 12 words back to back.
    for (int i = 0; i < 12; i++)
      tick(0, 0, 1, {4'hC, 4'(i), 4'(i + 1), 4'(i + 2)}, 1);
    chk("stream_count", 64'(bus.count), 64'd1);
    chk("stream_word", 64'({bus.opcode, bus.DR, bus.SA, bus.SB}), 64'h CABC);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 16'h0, 1);

    // Flush with data queued and a word offered.
    for (int i = 1; i <= 4; i++) tick(0, 0, 1, 16'hD000 + 16'(i), 0);
    chk("pre_flush_count", 64'(bus.count), 64'd3);
    tick(0, 1, 1, 16'hEEEE, 0);
    chk("flush_count", 64'(bus.count),     64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_word", 64'({bus.opcode, bus.DR, bus.SA, bus.SB}), 64'h D001);
    tick(0, 0, 0, 16'h0, 1);
    tick(0, 0, 0, 16'h0, 1);
    chk("flush_no_issue", 64'(bus.out_valid), 64'd0);

    // Reset while full and stalled.
    for (int i = 1; i <= 5; i++) tick(0, 0, 1, 16'hF000 + 16'(i), 0);
    tick(1, 1, 1, 16'h9999, 0);
    chk("mid_rst_valid",    64'(bus.out_valid), 64'd0);
    chk("mid_rst_count",    64'(bus.count),     64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready),  64'd1);
    chk("mid_rst_word", 64'({bus.opcode, bus.DR, bus.SA, bus.SB}), 64'h0);
    tick(0, 0, 1, 16'h5678, 1);
    tick(0, 0, 0, 16'h0, 0);
    chk("post_rst_opcode", 64'(bus.opcode), 64'd5);
    chk("post_rst_DR",     64'(bus.DR),     64'd6);
    chk("post_rst_SA",     64'(bus.SA),     64'd7);
    chk("post_rst_SB",     64'(bus.SB),     64'd8);

    // Mixed traffic, checked by the model only.
    for (int i = 0; i < 60; i++)
      tick(0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           16'($urandom), 1'($urandom_range(0, 2) != 0));

    // Wide instance.
    tick(1, 0, 0, 16'h0, 0);
    tick(0, 0, 0, 16'h0, 0);
    tick2(1, 32'h11223344, 1);
    tick2(0, 32'h0, 0);
    chk("wide_valid",  64'(bus2.out_valid), 64'd1);
    chk("wide_opcode", 64'(bus2.opcode), 64'h11);
    chk("wide_DR",     64'(bus2.DR),     64'h22);
    chk("wide_SA",     64'(bus2.SA),     64'h33);
    chk("wide_SB",     64'(bus2.SB),     64'h44);
    for (int i = 0; i < 8; i++) tick2(1, 32'h5500_0000 + 32'(i), 0);
    chk("wide_full_count",    64'(bus2.count),    64'd8);
    chk("wide_full_in_ready", 64'(bus2.in_ready), 64'd0);
    tick2(1, 32'hDEAD_BEEF, 0);
    chk("wide_full_hold", 64'(bus2.count), 64'd8);
    tick2(0, 32'h0, 1);
    chk("wide_load_opcode", 64'(bus2.opcode), 64'h55);
    chk("wide_load_SB",     64'(bus2.SB),     64'h00);
    chk("wide_load_count",  64'(bus2.count),  64'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter INS_W, default 16: instruction word width in bits.
REQ-002 Parameter FIELD_W, default 4: width of each decoded field; INS_W SHALL equal 4*FIELD_W.
REQ-003 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-004 Port clk_main  in  1  system clock; all state changes on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port flush  in  1  discards all queued and issued instructions.
REQ-007 Port in_valid  in  1  ins holds a word offered for enqueue.
REQ-008 Port ins  in  INS_W  instruction word.
REQ-009 Port in_ready  out  1  queue can accept a word this cycle.
REQ-010 Port out_valid  out  1  decoded output register holds an issued instruction.
REQ-011 Port out_ready  in  1  consumer takes the issued instruction this cycle.
REQ-012 Port opcode  out  FIELD_W  ins[INS_W-1 -: FIELD_W] of the issued word.
REQ-013 Port DR  out  FIELD_W  next field down, ins[3*FIELD_W-1 -: FIELD_W].
REQ-014 Port SA  out  FIELD_W  ins[2*FIELD_W-1 -: FIELD_W].
REQ-015 Port SB  out  FIELD_W  ins[FIELD_W-1:0].
REQ-016 Port count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register.

Function
REQ-017 Structure: a DEPTH-entry circular FIFO feeding one decoded output register; opcode/DR/SA/SB/out_valid come directly from flops.
REQ-018 in_ready SHALL equal (count < DEPTH) from registered state; there is no combinational path from out_ready.
REQ-019 Enqueue occurs when in_valid && in_ready && !flush: ins is written at the write pointer, and the pointer advances modulo DEPTH.
REQ-020 Issue condition: load = (count != 0) && (!out_valid || out_ready) && !flush.
REQ-021 On load, the FIFO head is split into opcode/DR/SA/SB, out_valid is set to 1, and the read pointer advances modulo DEPTH.
REQ-022 Consume without load: when out_valid && out_ready && count == 0, out_valid is set to 0 and the fields hold their values.
REQ-023 When out_valid=1 and out_ready=0, all output fields SHALL hold.
REQ-024 Simultaneous enqueue and load in one cycle leaves count unchanged; enqueue alone increments count; load alone decrements count.
REQ-025 Latency: a word accepted at edge N appears on the outputs with out_valid=1 after edge N+1 at the earliest; there is no FIFO bypass.
REQ-026 Order: instructions issue strictly in acceptance order; none is dropped or duplicated except by flush or reset.
REQ-027 Full: when count == DEPTH, in_ready=0 and ins is ignored; a load in that cycle lowers count, and in_ready rises the next cycle.
REQ-028 Empty: when count == 0, no load occurs; an out_valid output is unaffected except as described in REQ-022.
REQ-029 Pointer wrap: read and write pointers wrap from DEPTH-1 to 0 with no gap entry.
REQ-030 Flush: on the next edge, count=0, both pointers=0, and out_valid=0; fields hold their last values; an in_valid word in the flush cycle is dropped.
REQ-031 flush takes priority over enqueue, load, and consume in the same cycle.

Reset
REQ-032 When reset=1 at an edge: opcode, DR, SA, SB = 0; out_valid=0; count=0; pointers=0; in_ready=1 from the following cycle.
REQ-033 reset takes priority over flush and all handshakes, including mid-stream with a full FIFO and a stalled output.
REQ-034 FIFO storage contents need not be reset; no stale entry SHALL ever issue after reset.

Verification
REQ-035 Single word: after reset, drive ins=16'h1234 with in_valid for 1 cycle -> one edge later out_valid=1, opcode=1, DR=2, SA=3, SB=4, count=0.
REQ-036 Fill/stall: out_ready=0, offer 16'hA000..16'hA005 -> output holds A000, the FIFO accepts A001..A004, count=4, in_ready=0, A005 is held off until out_ready=1.
REQ-037 Streaming: in_valid=1 and out_ready=1 continuously for 12 words -> one issue per cycle in order, count stays 1, pointers wrap three times.
REQ-038 Flush with data: count=3, out_valid=1, pulse flush together with in_valid -> next cycle count=0, out_valid=0, fields unchanged, the offered word never issues.
REQ-039 Reset mid-operation: FIFO full, reset for 1 cycle -> all outputs 0, in_ready=1; the next word 16'h5678 issues with opcode=5, DR=6, SA=7, SB=8.
REQ-040 Parameter sweep: INS_W=32, FIELD_W=8, DEPTH=8 -> 16'h... widened word 32'h11223344 yields opcode=8'h11, DR=8'h22, SA=8'h33, SB=8'h44, and full at count=8.
